// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] scan;
  } key_entry_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - key event FIFO with registered head, ready and sticky overflow
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_entry_t push_data,
  input  logic       pop,
  output key_entry_t head,
  output logic       ready,
  output logic       overflow
);

  localparam int DEPTH = 1 << AW;

  key_entry_t    mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nxt;
  logic [AW:0]   count, count_nxt;
  logic          empty, full, do_pop, do_push;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign do_push  = push && (!full || do_pop);
  assign rptr_nxt = do_pop ? rptr + 1'b1 : rptr;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      head     <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      rptr  <= rptr_nxt;
      count <= count_nxt;
      ready <= (count_nxt != '0);
      // head keeps its last value when the FIFO drains; only ready drops
      if (count_nxt != '0 && (empty || do_pop))
        head <= (do_push && rptr_nxt == wptr) ? push_data : mem[rptr_nxt];
      if (do_pop)
        overflow <= 1'b0;
      else if (push && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver: conditioning, frame FSM, prefix decoder
// PS2_BREAK_FILTER_EN: when defined, break events are decoded but never queued.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [9:0] ps2kb_key,
  output logic       key_ext,
  output logic       overflow,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, dat_filt, sample;
  logic [FW-1:0] clk_cnt, dat_cnt;
  ps2_state_t    state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok, ext_f, brk_f;
  logic [TW-1:0] timer;
  logic          shift_en, par_en, byte_valid, err, timed_out, is_prefix, push;
  key_entry_t    head;
  logic          ready;

  // both lines use the same filter so data stays aligned with the clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      dat_filt <= 1'b1;
      clk_cnt  <= '0;
      dat_cnt  <= '0;
      sample   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      sample   <= clk_filt && !clk_sync[1] && (clk_cnt == FW'(FILTER_LEN - 1));
      if (clk_sync[1] == clk_filt)
        clk_cnt <= '0;
      else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else
        clk_cnt <= clk_cnt + 1'b1;
      if (dat_sync[1] == dat_filt)
        dat_cnt <= '0;
      else if (dat_cnt == FW'(FILTER_LEN - 1)) begin
        dat_filt <= dat_sync[1];
        dat_cnt  <= '0;
      end else
        dat_cnt <= dat_cnt + 1'b1;
    end
  end

  assign timed_out = !sample && (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    byte_valid = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE:   if (sample && !dat_filt) state_nxt = ST_DATA;
      ST_DATA:   if (sample) begin
                   shift_en = 1'b1;
                   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                 end
      ST_PARITY: if (sample) begin
                   par_en    = 1'b1;
                   state_nxt = ST_STOP;
                 end
      ST_STOP:   if (sample) begin
                   if (dat_filt && par_ok) byte_valid = 1'b1;
                   else                    err = 1'b1;
                   state_nxt = ST_IDLE;
                 end
      default:   state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && timed_out) begin
      state_nxt = ST_IDLE;
      err       = 1'b1;
    end
  end

  assign is_prefix = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BRK);
`ifdef PS2_BREAK_FILTER_EN
  assign push = byte_valid && !is_prefix && !brk_f;
`else
  assign push = byte_valid && !is_prefix;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      timer     <= '0;
      frame_err <= 1'b0;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= err;
      timer     <= (state == ST_IDLE || sample) ? '0 : timer + 1'b1;
      if (state == ST_IDLE)
        bit_cnt <= '0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)
        shreg <= {dat_filt, shreg[7:1]};
      if (par_en)
        par_ok <= ^{shreg, dat_filt};
      // prefix flags survive frame errors and only clear when an event is decoded
      if (byte_valid) begin
        if (shreg == PS2_PREFIX_EXT)
          ext_f <= 1'b1;
        else if (shreg == PS2_PREFIX_BRK)
          brk_f <= 1'b1;
        else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end
      end
    end
  end

  ps2_key_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ext_f, brk_f, shreg}),
    .pop       (rd),
    .head      (head),
    .ready     (ready),
    .overflow  (overflow)
  );

  assign ps2kb_key = {ready, head.brk, head.scan};
  assign key_ext   = head.ext;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - directed bench with a queue model of the keyboard event FIFO
module tb_ps2_keyboard;

  localparam int FIFO_AW    = 3;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int H          = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic [9:0] ps2kb_key;
  logic       key_ext, overflow, frame_err;

  always #5 clk = ~clk;

  ps2_keyboard #(.FIFO_AW(FIFO_AW), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd        (rd),
    .ps2kb_key (ps2kb_key),
    .key_ext   (key_ext),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int n_pass = 0, n_total = 0;
  int err_seen = 0, exp_err = 0;
  bit chk_en = 1'b0;

  // model entries are {ext, brk, scan}
  logic [9:0] mq[$];
  logic [9:0] m_last = '0;
  logic       m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [9:0] exp_key();
    return (mq.size() != 0) ? {1'b1, mq[0][8:0]} : {1'b0, m_last[8:0]};
  endfunction

  function automatic logic exp_ext();
    return (mq.size() != 0) ? mq[0][9] : m_last[9];
  endfunction

  task automatic m_push(input logic [9:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic m_pop();
    if (mq.size() != 0) begin
      m_last = mq.pop_front();
      m_ovf  = 1'b0;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_BREAK_FILTER_EN
      if (!m_brk) m_push({m_ext, m_brk, b});
`else
      m_push({m_ext, m_brk, b});
`endif
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (chk_en) begin
      check("key", ps2kb_key, exp_key());
      check("ext", key_ext, exp_ext());
      check("ovf", overflow, m_ovf);
      check("err_count", err_seen, exp_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_flip, input bit stop_v);
    return {stop_v, (~(^b)) ^ par_flip, b, 1'b0};
  endfunction

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = frame_bits(b, 1'b0, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_v, input bit rd_at_push);
    logic [10:0] bits;
    bits   = frame_bits(b, par_flip, stop_v);
    chk_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      cyc(H);
      ps2_clk = 1'b0;
      if (i == 10 && rd_at_push) begin
        // pop lands on the same edge as the push of this stop bit
        cyc(FILTER_LEN + 2);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        cyc(H - FILTER_LEN - 3);
      end else
        cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(H);
    if (rd_at_push) m_pop();
    if (!par_flip && stop_v) m_byte(b);
    else exp_err++;
    chk_en = 1'b1;
    cyc(4);
  endtask

  task automatic do_rd();
    chk_en = 1'b0;
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    cyc(1);
    m_pop();
    chk_en = 1'b1;
    cyc(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys [9];
    keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    cyc(5);
    check("rst_key", ps2kb_key, 10'h000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_err", frame_err, 1'b0);
    rst = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    cyc(5);

    send_frame(8'h1C, 0, 1, 0);
    check("make_1c", ps2kb_key, 10'h21C);
    do_rd();
    check("rd_1c", ps2kb_key, 10'h01C);

    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
`ifdef PS2_BREAK_FILTER_EN
    check("brk_filtered", ps2kb_key, 10'h01C);
`else
    check("brk_1c", ps2kb_key, 10'h31C);
    check("brk_1c_ext", key_ext, 1'b0);
    do_rd();
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h75, 0, 1, 0);
    check("ext_brk_75", ps2kb_key, 10'h375);
    check("ext_brk_75_ext", key_ext, 1'b1);
    do_rd();
`endif

    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'h1C, 0, 0, 0);
    check("bad_frames_err", err_seen, 2);
    check("bad_frames_empty", ps2kb_key[9], 1'b0);

    foreach (keys[i]) send_frame(keys[i], 0, 1, 0);
    check("full_ovf", overflow, 1'b1);
    check("full_head", ps2kb_key, 10'h215);
    do_rd();
    check("pop_ovf", overflow, 1'b0);
    check("pop_head", ps2kb_key, 10'h21D);
    send_frame(8'h4B, 0, 1, 0);
    send_frame(8'h4D, 0, 1, 1);
    check("simul_ovf", overflow, 1'b0);
    check("simul_head", ps2kb_key, 10'h224);
    repeat (DEPTH) do_rd();
    check("drain_last", ps2kb_key, 10'h04D);

    chk_en = 1'b0;
    send_partial(8'h29, 5);
    cyc(TIMEOUT + 100);
    exp_err++;
    chk_en = 1'b1;
    cyc(4);
    check("timeout_err", err_seen, 3);
    send_frame(8'h29, 0, 1, 0);
    check("after_timeout", ps2kb_key, 10'h229);
    do_rd();

    chk_en = 1'b0;
    send_partial(8'h5A, 3);
    rst = 1'b0;
    cyc(3);
    mq.delete();
    m_last = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_ovf  = 1'b0;
    check("midrst_key", ps2kb_key, 10'h000);
    rst = 1'b1;
    cyc(5);
    ps2_data = 1'b0;
    cyc(20);
    ps2_clk = 1'b0;
    cyc(FILTER_LEN - 3);
    ps2_clk = 1'b1;
    cyc(20);
    ps2_data = 1'b1;
    cyc(30);
    chk_en = 1'b1;
    cyc(4);
    check("glitch_key", ps2kb_key, 10'h000);
    check("glitch_ext", key_ext, 1'b0);
    check("glitch_err", err_seen, 3);
    send_frame(8'h1C, 0, 1, 0);
    check("post_rst_1c", ps2kb_key, 10'h21C);

    chk_en = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
